// File: rtl/mic_adc_ctrl.sv
// mic_adc_ctrl
//   Serial-ADC capture controller for the microphone front end. Generates
//   ncs/sclk for an ADCS7476-style converter (ncs low, LEAD_BITS zeros, then
//   DATA_W data bits MSB first), paces conversions from an internal
//   sample-rate tick (mode 0) or from trig (mode 1), and hands samples to a
//   valid/ready consumer through a one-entry holding register.
//
//   Optional build macro: MIC_AVG_EN -- average 2^AVG_LOG2 consecutive frames
//   and deliver one truncated mean per group instead of every frame.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active low
//   mode       0 = free-run on internal tick, 1 = triggered
//   trig       single-cycle start request (mode 1)
//   sdata      ADC serial data
//   sclk       ADC serial clock, idles high
//   ncs        ADC chip select, active low
//   out_data   captured sample (unsigned)
//   out_valid  out_data holds an unconsumed sample
//   out_ready  consumer accepts when out_valid && out_ready
//   busy       conversion in progress (ncs low)
//   overrun    sticky: an unconsumed sample was overwritten
//   frame_err  sticky: a leading bit was sampled as 1
//   clr_flags  clears overrun and frame_err (a coincident set wins)
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | ncs=1, sclk=1, waiting for tick (mode 0) or trig (mode 1)
// S_SETUP | ncs=0, sclk=1 for CLK_DIV cycles before the first bit
// S_SHIFT | CLK_DIV low + CLK_DIV high per bit, sdata taken on the rise
// S_HOLD  | ncs=1 for one cycle, captured frame commits to the output

module mic_adc_ctrl #(
  parameter int DATA_W        = 12,
  parameter int LEAD_BITS     = 4,
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 2268,
  parameter int AVG_LOG2      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              trig,
  input  logic              sdata,
  output logic              sclk,
  output logic              ncs,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              overrun,
  output logic              frame_err,
  input  logic              clr_flags
);

  localparam int FRAME_BITS = LEAD_BITS + DATA_W;
  localparam int TW = $clog2(SAMPLE_PERIOD);
  localparam int PW = $clog2(CLK_DIV);
  localparam int BW = $clog2(FRAME_BITS + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_PERIOD - 1);
  localparam logic [PW-1:0] PH_LOAD   = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BITS_LOAD = BW'(FRAME_BITS);
  localparam logic [BW-1:0] DATA_BITS = BW'(DATA_W);

  if (DATA_W < 4 || DATA_W > 16) begin : g_bad_data_w
    $error("mic_adc_ctrl: DATA_W must be in 4..16");
  end
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("mic_adc_ctrl: CLK_DIV must be at least 2");
  end
  if (SAMPLE_PERIOD < 2 * CLK_DIV * FRAME_BITS + 4) begin : g_bad_period
    $error("mic_adc_ctrl: SAMPLE_PERIOD too short for one frame");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD
  } state_t;

  state_t            state;
  logic [TW-1:0]     tick_cnt;
  logic              tick;
  logic [PW-1:0]     ph_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] sr;

  logic              start;
  logic              sample_edge;
  logic              lead_err;
  logic              commit;
  logic [DATA_W-1:0] commit_data;

  // Free-running sample-rate counter; runs in both modes so switching to
  // mode 0 keeps the established sample grid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  assign start       = (state == S_IDLE) && (mode ? trig : tick);
  // sdata is taken on the edge that drives sclk 0->1
  assign sample_edge = (state == S_SHIFT) && (ph_cnt == '0) && !sclk;
  // bit_cnt still counts the bit being sampled, so values above DATA_W are leads
  assign lead_err    = sample_edge && sdata && (bit_cnt > DATA_BITS);

`ifdef MIC_AVG_EN
  localparam int AW = DATA_W + AVG_LOG2;

  if (AVG_LOG2 < 1) begin : g_bad_avg
    $error("mic_adc_ctrl: AVG_LOG2 must be at least 1 with averaging");
  end

  logic [AW-1:0]       acc;
  logic [AW-1:0]       acc_sum;
  logic [AVG_LOG2-1:0] grp;

  assign acc_sum     = acc + AW'(sr);
  // grp all-ones marks the last frame of a 2^AVG_LOG2 group
  assign commit      = (state == S_HOLD) && (grp == '1);
  assign commit_data = acc_sum[AW-1:AVG_LOG2];
`else
  assign commit      = (state == S_HOLD);
  assign commit_data = sr;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      sclk      <= 1'b1;
      ncs       <= 1'b1;
      busy      <= 1'b0;
      ph_cnt    <= '0;
      bit_cnt   <= '0;
      sr        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
`ifdef MIC_AVG_EN
      acc       <= '0;
      grp       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_SETUP;
            ncs     <= 1'b0;
            busy    <= 1'b1;
            ph_cnt  <= PH_LOAD;
            bit_cnt <= BITS_LOAD;
          end
        end
        S_SETUP: begin
          if (ph_cnt == '0) begin
            state  <= S_SHIFT;
            sclk   <= 1'b0;
            ph_cnt <= PH_LOAD;
          end else begin
            ph_cnt <= ph_cnt - 1'b1;
          end
        end
        S_SHIFT: begin
          if (ph_cnt != '0) begin
            ph_cnt <= ph_cnt - 1'b1;
          end else if (!sclk) begin
            sclk    <= 1'b1;
            sr      <= {sr[DATA_W-2:0], sdata};
            bit_cnt <= bit_cnt - 1'b1;
            ph_cnt  <= PH_LOAD;
          end else if (bit_cnt == '0) begin
            state <= S_HOLD;
            ncs   <= 1'b1;
            busy  <= 1'b0;
          end else begin
            sclk   <= 1'b0;
            ph_cnt <= PH_LOAD;
          end
        end
        S_HOLD: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

`ifdef MIC_AVG_EN
      if (state == S_HOLD) begin
        if (commit) begin
          acc <= '0;
          grp <= '0;
        end else begin
          acc <= acc_sum;
          grp <= grp + 1'b1;
        end
      end
`endif

      // Holding register: a commit always loads; a consume without a
      // commit empties it but leaves out_data unchanged.
      if (commit) begin
        out_data  <= commit_data;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (commit && out_valid && !out_ready) begin
        overrun <= 1'b1;
      end else if (clr_flags) begin
        overrun <= 1'b0;
      end

      if (lead_err) begin
        frame_err <= 1'b1;
      end else if (clr_flags) begin
        frame_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mic_adc_ctrl.sv
module tb_mic_adc_ctrl;

  localparam int DATA_W        = 12;
  localparam int LEAD_BITS     = 4;
  localparam int CLK_DIV       = 4;
  localparam int SAMPLE_PERIOD = 200;
  localparam int AVG_LOG2      = 2;
  localparam int AVG_N         = 1 << AVG_LOG2;
  localparam int FRAME_BITS    = LEAD_BITS + DATA_W;
  // edges from the start edge to out_valid visible, start edge included
  localparam int LAT           = 1 + CLK_DIV + 2 * CLK_DIV * FRAME_BITS + 1;

  logic              clk;
  logic              rst;
  logic              mode;
  logic              trig;
  logic              sdata;
  logic              sclk;
  logic              ncs;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              overrun;
  logic              frame_err;
  logic              clr_flags;

  mic_adc_ctrl #(
    .DATA_W(DATA_W),
    .LEAD_BITS(LEAD_BITS),
    .CLK_DIV(CLK_DIV),
    .SAMPLE_PERIOD(SAMPLE_PERIOD),
    .AVG_LOG2(AVG_LOG2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mode(mode),
    .trig(trig),
    .sdata(sdata),
    .sclk(sclk),
    .ncs(ncs),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy),
    .overrun(overrun),
    .frame_err(frame_err),
    .clr_flags(clr_flags)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // ADC model: word latched when ncs falls, MSB presented at once, next bit
  // after each sclk rise (the controller samples on the rise).
  logic [15:0] next_word;
  logic [15:0] cur_word;
  int          bidx;
  int          win_rises;
  int          last_rises;
  int          nfall;

  initial begin
    sdata = 1'b0;
    win_rises = 0;
    last_rises = 0;
    forever begin
      @(negedge ncs);
      cur_word = next_word;
      bidx = FRAME_BITS - 1;
      win_rises = 0;
      sdata = cur_word[bidx];
      while (ncs === 1'b0) begin
        @(posedge sclk or posedge ncs);
        if (ncs === 1'b0) begin
          win_rises++;
          if (bidx > 0) begin
            bidx--;
            sdata = cur_word[bidx];
          end
        end
      end
      last_rises = win_rises;
    end
  end

  initial begin
    nfall = 0;
    forever begin
      @(negedge ncs);
      nfall++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // Trigger one frame with out_ready low, raise out_ready to rdy_commit for
  // the commit edge and the edge after it, and return after that edge.
  task automatic run_frame(input logic [15:0] w, input logic rdy_commit);
    next_word = w;
    out_ready = 1'b0;
    trig = 1'b1;
    step();
    trig = 1'b0;
    repeat (LAT - 2) step();
    out_ready = rdy_commit;
    step();
    step();
    out_ready = 1'b0;
  endtask

  // Behavioural reference: a conversion is a window of LAT edges; the
  // sample lands on the last of them and feeds the holding-register rules.
  bit          m_valid;
  logic [11:0] m_data;
  bit          m_ovr;
  bit          m_ferr;
  bit          m_pend;
  int          m_pend_edge;
  int          m_free;
  logic [11:0] m_pend_data;
  bit          m_pend_err;
  int          m_acc;
  int          m_grp;

  task automatic model_reset();
    m_valid = 0; m_data = '0; m_ovr = 0; m_ferr = 0;
    m_pend = 0; m_pend_edge = 0; m_free = 0;
    m_pend_data = '0; m_pend_err = 0; m_acc = 0; m_grp = 0;
  endtask

  task automatic model_edge(input int e, input bit t, input bit r, input bit c);
    bit          deliver;
    bit          set_ovr;
    bit          set_ferr;
    logic [11:0] d;
    deliver = 0; set_ovr = 0; set_ferr = 0; d = '0;
    if (m_pend && e == m_pend_edge) begin
      m_pend = 0;
      set_ferr = m_pend_err;
`ifdef MIC_AVG_EN
      m_acc += int'(m_pend_data);
      m_grp++;
      if (m_grp == AVG_N) begin
        deliver = 1;
        d = 12'(m_acc / AVG_N);
        m_acc = 0;
        m_grp = 0;
      end
`else
      deliver = 1;
      d = m_pend_data;
`endif
    end
    if (deliver) begin
      if (m_valid && !r) set_ovr = 1;
      m_valid = 1;
      m_data = d;
    end else if (m_valid && r) begin
      m_valid = 0;
    end
    if (set_ovr) m_ovr = 1; else if (c) m_ovr = 0;
    if (set_ferr) m_ferr = 1; else if (c) m_ferr = 0;
    if (t && !m_pend && e >= m_free) begin
      m_pend = 1;
      m_pend_edge = e + LAT - 1;
      m_free = e + LAT;
      m_pend_data = next_word[11:0];
      m_pend_err = |next_word[15:12];
    end
  endtask

  typedef struct {
    logic [15:0] word;
    logic        rdy;
    logic        cleanup;
    logic [11:0] exp_data;
    logic        exp_valid;
    logic        exp_ovr;
    logic        exp_ferr;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int pulses[$];
    int base;
    int cnt;
    int lat;
    logic [11:0] got;
    bit seen;

    rst = 1'b0; mode = 1'b1; trig = 1'b0; out_ready = 1'b0;
    clr_flags = 1'b0; next_word = '0;

    // reset values on the first edge with rst low
    step();
    chk("rst_sclk", sclk, 1'b1);
    chk("rst_ncs", ncs, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 12'h0);
    chk("rst_ovr", overrun, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    step();
    rst = 1'b1;

    // free-run: conversions every SAMPLE_PERIOD cycles from the tick
    mode = 1'b0;
    out_ready = 1'b1;
    next_word = 16'h0A5C;
    for (int k = 0; k < 900; k++) begin
      step();
      if (out_valid === 1'b1) begin
        pulses.push_back(k);
        chk($sformatf("fr_data@%0d", k), out_data, 12'hA5C);
      end
    end
`ifndef MIC_AVG_EN
    chk("fr_npulse", pulses.size(), 3);
    for (int i = 1; i < pulses.size(); i++)
      chk($sformatf("fr_interval%0d", i), pulses[i] - pulses[i-1], SAMPLE_PERIOD);
`endif
    chk("fr_sclk_rises", last_rises, FRAME_BITS);
    mode = 1'b1;
    repeat (LAT + 6) step();
    do_reset();

    // triggered: second trig while busy ignored, third after HOLD starts again
    out_ready = 1'b1;
    next_word = 16'h0321;
    base = nfall;
    trig = 1'b1;
    step();
    trig = 1'b0;
    cnt = 1;
    lat = 0;
    got = '0;
    while (cnt < 150) begin
      if (cnt == 10) trig = 1'b1;
      step();
      trig = 1'b0;
      cnt++;
      if (out_valid === 1'b1 && lat == 0) begin
        lat = cnt;
        got = out_data;
      end
    end
`ifndef MIC_AVG_EN
    chk("trg_latency", lat, LAT);
    chk("trg_data", got, 12'h321);
`endif
    chk("trg_one_frame", nfall - base, 1);
    chk("trg_sclk_rises", last_rises, FRAME_BITS);
    next_word = 16'h0654;
    trig = 1'b1;
    step();
    trig = 1'b0;
    repeat (LAT + 6) step();
    chk("trg_two_frames", nfall - base, 2);
`ifndef MIC_AVG_EN
    chk("trg_data2", out_data, 12'h654);
`endif
    out_ready = 1'b0;
    do_reset();

`ifndef MIC_AVG_EN
    tbl[0] = '{16'h0123, 1'b0, 1'b0, 12'h123, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{16'h0456, 1'b0, 1'b1, 12'h456, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{16'h0789, 1'b0, 1'b0, 12'h789, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{16'h0ABC, 1'b1, 1'b0, 12'hABC, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{16'h40FF, 1'b1, 1'b1, 12'h0FF, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{16'h0FFF, 1'b0, 1'b0, 12'hFFF, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{16'h0000, 1'b0, 1'b1, 12'h000, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{16'h8001, 1'b0, 1'b1, 12'h001, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      run_frame(tbl[i].word, tbl[i].rdy);
      chk($sformatf("tbl%0d_data", i), out_data, tbl[i].exp_data);
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].exp_valid);
      chk($sformatf("tbl%0d_ovr", i), overrun, tbl[i].exp_ovr);
      chk($sformatf("tbl%0d_ferr", i), frame_err, tbl[i].exp_ferr);
      if (tbl[i].cleanup) begin
        clr_flags = 1'b1;
        out_ready = 1'b1;
        step();
        clr_flags = 1'b0;
        out_ready = 1'b0;
        chk($sformatf("tbl%0d_clr_valid", i), out_valid, 1'b0);
        chk($sformatf("tbl%0d_clr_ovr", i), overrun, 1'b0);
        chk($sformatf("tbl%0d_clr_ferr", i), frame_err, 1'b0);
        chk($sformatf("tbl%0d_hold_data", i), out_data, tbl[i].exp_data);
      end
    end

    // clr_flags held across an overrunning commit: the set wins
    run_frame(16'h0111, 1'b0);
    next_word = 16'h0222;
    trig = 1'b1;
    step();
    trig = 1'b0;
    clr_flags = 1'b1;
    repeat (LAT - 1) step();
    clr_flags = 1'b0;
    chk("setwin_ovr", overrun, 1'b1);
    chk("setwin_data", out_data, 12'h222);
    chk("setwin_valid", out_valid, 1'b1);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    chk("setwin_clr", overrun, 1'b0);
`else
    begin
      logic [15:0] avg_words[4];
      avg_words[0] = 16'h0100;
      avg_words[1] = 16'h0101;
      avg_words[2] = 16'h0102;
      avg_words[3] = 16'h0104;
      for (int i = 0; i < 4; i++) begin
        run_frame(avg_words[i], 1'b0);
        if (i < 3) begin
          chk($sformatf("avg%0d_novalid", i), out_valid, 1'b0);
        end else begin
          chk("avg_valid", out_valid, 1'b1);
          chk("avg_data", out_data, 12'h101);
        end
      end
    end
`endif

    // reset mid-SHIFT aborts the frame and clears everything
    run_frame(16'h2055, 1'b0);
    chk("pre_rst_ferr", frame_err, 1'b1);
    next_word = 16'h0333;
    trig = 1'b1;
    step();
    trig = 1'b0;
    repeat (60) step();
    chk("pre_rst_busy", busy, 1'b1);
    rst = 1'b0;
    step();
    chk("mrst_sclk", sclk, 1'b1);
    chk("mrst_ncs", ncs, 1'b1);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_valid", out_valid, 1'b0);
    chk("mrst_data", out_data, 12'h0);
    chk("mrst_ovr", overrun, 1'b0);
    chk("mrst_ferr", frame_err, 1'b0);
    repeat (4) step();
    rst = 1'b1;
    base = nfall;
    seen = 0;
    repeat (200) begin
      step();
      if (out_valid !== 1'b0) seen = 1;
    end
    chk("mrst_no_delivery", seen, 1'b0);
    chk("mrst_no_frame", nfall - base, 0);

    // randomized triggered traffic against the reference model
    do_reset();
    model_reset();
    for (int e = 0; e < 6000 && errors < 50; e++) begin
      bit t;
      bit r;
      bit c;
      t = ($urandom_range(0, 24) == 0);
      r = $urandom_range(0, 1) != 0;
      c = !m_pend && !t && ($urandom_range(0, 9) == 0);
      if (t)
        next_word = {(($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'h0),
                     12'($urandom)};
      trig = t;
      out_ready = r;
      clr_flags = c;
      model_edge(e, t, r, c);
      step();
      chk($sformatf("rnd_valid@%0d", e), out_valid, m_valid);
      chk($sformatf("rnd_data@%0d", e), out_data, m_data);
      chk($sformatf("rnd_ovr@%0d", e), overrun, m_ovr);
      if (!m_pend)
        chk($sformatf("rnd_ferr@%0d", e), frame_err, m_ferr);
    end
    trig = 1'b0;
    clr_flags = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
